// File: rtl/fix_seq_checker.sv
// -----------------------------------------------------------------------------
// fix_seq_checker
//
// Receive-side FIX MsgSeqNum checker. It sits between the header parser and
// the session FSM. For every parsed inbound header it holds the expected
// inbound sequence number. It gives each message exactly one verdict: accept,
// ignore, gap or fatal. On a gap it raises a ResendRequest range towards the
// session layer.
//
// Optional feature macro: FIX_SEQ_POSSDUP_EN
//   defined   : seq < expected with PossDupFlag=Y is tolerated (ignore_o)
//   undefined : poss_dup_i is unused; any seq < expected is fatal
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-low reset
//   connect_i           session start pulse: expected = 1, state ACTIVE
//   disconnect_i        session end pulse: state IDLE, resend request dropped
//   msg_valid_i         one-cycle strobe, header fields below are valid
//   msg_seq_num_i       MsgSeqNum(34)
//   poss_dup_i          PossDupFlag(43) = Y
//   seq_reset_i         message is SequenceReset(35=4)
//   gap_fill_i          GapFillFlag(123) = Y
//   new_seq_num_i       NewSeqNo(36)
//   resend_ready_i      downstream accepts the resend request
//   expected_seq_num_o  next expected inbound sequence number
//   accept_o/ignore_o/gap_o/fatal_o  registered verdict pulses, one-hot or zero
//   resend_valid_o      resend request pending
//   resend_begin_o      BeginSeqNo of the pending request
//   resend_end_o        EndSeqNo of the pending request
//   recovering_o        high while in RECOVER
//   fsm_state           debug view of the FSM: 0 IDLE, 1 ACTIVE, 2 RECOVER, 3 HALT
//
// Resend handshake (valid/ready):
//   resend_valid_o rises in the same cycle as gap_o. While it is high,
//   resend_begin_o and resend_end_o do not change, except when a further gap
//   arrives. In that case begin is kept and end is replaced by the new seq.
//   The request is consumed in the cycle where resend_valid_o & resend_ready_i.
//   resend_valid_o is low from the following cycle, unless that same edge
//   also loads a fresh gap. connect_i, disconnect_i and rst drop a pending
//   request.
//
// Timing: header fields are sampled on a rising edge. The verdict,
// expected_seq_num_o and the state all update on that edge, and the verdict
// pulse lasts one cycle. Back-to-back messages are classified against the
// expected value left by their predecessor.
// -----------------------------------------------------------------------------
module fix_seq_checker #(
  parameter int MAX_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                connect_i,
  input  logic                disconnect_i,
  input  logic                msg_valid_i,
  input  logic [MAX_SIZE-1:0] msg_seq_num_i,
  input  logic                poss_dup_i,
  input  logic                seq_reset_i,
  input  logic                gap_fill_i,
  input  logic [MAX_SIZE-1:0] new_seq_num_i,
  input  logic                resend_ready_i,
  output logic [MAX_SIZE-1:0] expected_seq_num_o,
  output logic                accept_o,
  output logic                ignore_o,
  output logic                gap_o,
  output logic                fatal_o,
  output logic                resend_valid_o,
  output logic [MAX_SIZE-1:0] resend_begin_o,
  output logic [MAX_SIZE-1:0] resend_end_o,
  output logic                recovering_o,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_RECOVER = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [MAX_SIZE-1:0] SEQ_ZERO = '0;
  localparam logic [MAX_SIZE-1:0] SEQ_ONE  = MAX_SIZE'(1);
  localparam logic [MAX_SIZE-1:0] SEQ_MAX  = '1;

  state_t              state, state_nxt;
  logic [MAX_SIZE-1:0] exp_seq, exp_nxt;
  logic [MAX_SIZE-1:0] rec_end, rec_end_nxt;
  logic                rv, rv_nxt;
  logic [MAX_SIZE-1:0] rb, rb_nxt;
  logic [MAX_SIZE-1:0] re, re_nxt;
  logic                acc_r, ign_r, gap_r, fat_r;
  logic                acc_nxt, ign_nxt, gap_nxt, fat_nxt;

  logic                handshake;
  logic                req_outstanding;
  logic                is_reset_mode;
  logic                is_gap_fill;
  logic [MAX_SIZE-1:0] exp_inc;

`ifndef FIX_SEQ_POSSDUP_EN
  // PossDupFlag has no effect in this build.
  logic unused_poss_dup;
  assign unused_poss_dup = poss_dup_i;
`endif

  assign handshake       = rv & resend_ready_i;
  // A request that is still pending after this edge. A new gap merges into it.
  assign req_outstanding = rv & ~resend_ready_i;
  // SequenceReset in reset mode ignores MsgSeqNum entirely.
  assign is_reset_mode   = seq_reset_i & ~gap_fill_i;
  assign is_gap_fill     = seq_reset_i & gap_fill_i;
  // 0 is never a valid expected value, so the counter wraps from all-ones to 1.
  assign exp_inc         = (exp_seq == SEQ_MAX) ? SEQ_ONE : exp_seq + SEQ_ONE;

  // ---------------------------------------------------------------------------
  // Next-state, next-counter and verdict logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    exp_nxt     = exp_seq;
    rec_end_nxt = rec_end;
    rv_nxt      = rv;
    rb_nxt      = rb;
    re_nxt      = re;
    acc_nxt     = 1'b0;
    ign_nxt     = 1'b0;
    gap_nxt     = 1'b0;
    fat_nxt     = 1'b0;

    if (handshake) begin
      rv_nxt = 1'b0;
    end

    if (disconnect_i) begin
      state_nxt = S_IDLE;
      rv_nxt    = 1'b0;
    end else if (connect_i) begin
      state_nxt = S_ACTIVE;
      exp_nxt   = SEQ_ONE;
      rv_nxt    = 1'b0;
    end else if (msg_valid_i) begin
      if (state == S_IDLE || state == S_HALT) begin
        ign_nxt = 1'b1;
      end else if (is_reset_mode) begin
        if (new_seq_num_i > exp_seq) begin
          acc_nxt = 1'b1;
          exp_nxt = new_seq_num_i;
        end else if (new_seq_num_i == exp_seq) begin
          acc_nxt = 1'b1;
        end else begin
          fat_nxt   = 1'b1;
          state_nxt = S_HALT;
        end
      end else if (msg_seq_num_i == SEQ_ZERO) begin
        fat_nxt   = 1'b1;
        state_nxt = S_HALT;
      end else if (msg_seq_num_i == exp_seq) begin
        if (is_gap_fill) begin
          // A gap fill must move the counter strictly forward.
          if (new_seq_num_i > msg_seq_num_i) begin
            acc_nxt = 1'b1;
            exp_nxt = new_seq_num_i;
          end else begin
            fat_nxt   = 1'b1;
            state_nxt = S_HALT;
          end
        end else begin
          acc_nxt = 1'b1;
          exp_nxt = exp_inc;
        end
      end else if (msg_seq_num_i > exp_seq) begin
        if (state == S_ACTIVE) begin
          gap_nxt     = 1'b1;
          rec_end_nxt = msg_seq_num_i;
          re_nxt      = msg_seq_num_i;
          rv_nxt      = 1'b1;
          if (!req_outstanding) begin
            rb_nxt = exp_seq;
          end
          state_nxt   = S_RECOVER;
        end else begin
          // Already recovering: the outstanding request covers this range.
          ign_nxt = 1'b1;
        end
      end else begin
`ifdef FIX_SEQ_POSSDUP_EN
        if (poss_dup_i) begin
          ign_nxt = 1'b1;
        end else begin
          fat_nxt   = 1'b1;
          state_nxt = S_HALT;
        end
`else
        fat_nxt   = 1'b1;
        state_nxt = S_HALT;
`endif
      end

      // Recovery ends on the edge where expected moves past the gap end.
      if (acc_nxt && state == S_RECOVER && exp_nxt > rec_end) begin
        state_nxt = S_ACTIVE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      exp_seq <= '0;
      rec_end <= '0;
      rv      <= 1'b0;
      rb      <= '0;
      re      <= '0;
      acc_r   <= 1'b0;
      ign_r   <= 1'b0;
      gap_r   <= 1'b0;
      fat_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      exp_seq <= exp_nxt;
      rec_end <= rec_end_nxt;
      rv      <= rv_nxt;
      rb      <= rb_nxt;
      re      <= re_nxt;
      acc_r   <= acc_nxt;
      ign_r   <= ign_nxt;
      gap_r   <= gap_nxt;
      fat_r   <= fat_nxt;
    end
  end

  assign expected_seq_num_o = exp_seq;
  assign accept_o           = acc_r;
  assign ignore_o           = ign_r;
  assign gap_o              = gap_r;
  assign fatal_o            = fat_r;
  assign resend_valid_o     = rv;
  assign resend_begin_o     = rb;
  assign resend_end_o       = re;
  assign recovering_o       = (state == S_RECOVER);
  assign fsm_state          = state;

endmodule

// File: tb/tb_fix_seq_checker.sv
// -----------------------------------------------------------------------------
// Testbench for fix_seq_checker (MAX_SIZE = 8).
// Each message pushes {verdict, expected_after} onto exp_q. A negedge monitor
// pops and compares that entry when the verdict is due. State and resend
// outputs are checked inline by each scenario task.
// Verdict encoding: {accept, ignore, gap, fatal}.
// -----------------------------------------------------------------------------
module tb_fix_seq_checker;

  localparam int W = 8;
  localparam logic [3:0] V_ACC = 4'b1000;
  localparam logic [3:0] V_IGN = 4'b0100;
  localparam logic [3:0] V_GAP = 4'b0010;
  localparam logic [3:0] V_FAT = 4'b0001;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         connect_i = 1'b0;
  logic         disconnect_i = 1'b0;
  logic         msg_valid_i = 1'b0;
  logic [W-1:0] msg_seq_num_i = '0;
  logic         poss_dup_i = 1'b0;
  logic         seq_reset_i = 1'b0;
  logic         gap_fill_i = 1'b0;
  logic [W-1:0] new_seq_num_i = '0;
  logic         resend_ready_i = 1'b0;
  logic [W-1:0] expected_seq_num_o;
  logic         accept_o, ignore_o, gap_o, fatal_o;
  logic         resend_valid_o;
  logic [W-1:0] resend_begin_o, resend_end_o;
  logic         recovering_o;
  logic [1:0]   fsm_state;

  int total = 0;
  int bad = 0;

  logic [W+3:0] exp_q[$];
  logic         expect_now = 1'b0;
  logic [W+3:0] mon_e;
  logic [3:0]   mon_obs;

  fix_seq_checker #(.MAX_SIZE(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .connect_i          (connect_i),
    .disconnect_i       (disconnect_i),
    .msg_valid_i        (msg_valid_i),
    .msg_seq_num_i      (msg_seq_num_i),
    .poss_dup_i         (poss_dup_i),
    .seq_reset_i        (seq_reset_i),
    .gap_fill_i         (gap_fill_i),
    .new_seq_num_i      (new_seq_num_i),
    .resend_ready_i     (resend_ready_i),
    .expected_seq_num_o (expected_seq_num_o),
    .accept_o           (accept_o),
    .ignore_o           (ignore_o),
    .gap_o              (gap_o),
    .fatal_o            (fatal_o),
    .resend_valid_o     (resend_valid_o),
    .resend_begin_o     (resend_begin_o),
    .resend_end_o       (resend_end_o),
    .recovering_o       (recovering_o),
    .fsm_state          (fsm_state)
  );

  // A verdict is due one edge after a message that connect/disconnect did not pre-empt.
  always @(posedge clk) begin
    expect_now = rst & msg_valid_i & ~connect_i & ~disconnect_i;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    mon_obs = {accept_o, ignore_o, gap_o, fatal_o};
    if (expect_now || mon_obs != 4'b0000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL verdict_unexpected: got verdict=%b exp_seq=%0d, required no verdict", mon_obs, expected_seq_num_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mon_obs, expected_seq_num_o} !== mon_e) begin
          bad++;
          $display("FAIL verdict: got verdict=%b exp_seq=%0d, required verdict=%b exp_seq=%0d",
                   mon_obs, expected_seq_num_o, mon_e[W+3:W], mon_e[W-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic clear_inputs();
    msg_valid_i   = 1'b0;
    poss_dup_i    = 1'b0;
    seq_reset_i   = 1'b0;
    gap_fill_i    = 1'b0;
    connect_i     = 1'b0;
    disconnect_i  = 1'b0;
  endtask

  task automatic send_msg(input logic [W-1:0] seq, input logic pd, input logic sr, input logic gf,
                          input logic [W-1:0] nsn, input logic [3:0] v, input logic [W-1:0] e);
    @(negedge clk);
    clear_inputs();
    msg_valid_i   = 1'b1;
    msg_seq_num_i = seq;
    poss_dup_i    = pd;
    seq_reset_i   = sr;
    gap_fill_i    = gf;
    new_seq_num_i = nsn;
    exp_q.push_back({v, e});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic do_connect();
    @(negedge clk);
    clear_inputs();
    connect_i = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  // scenarios
  task automatic test_reset();
    #1;
    total++;
    if ({accept_o, ignore_o, gap_o, fatal_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_verdicts: got %b, required 0000", {accept_o, ignore_o, gap_o, fatal_o});
    end
    total++;
    if (expected_seq_num_o !== 8'd0 || fsm_state !== ST_IDLE || recovering_o !== 1'b0) begin
      bad++; $display("FAIL reset_state: got exp=%0d state=%0d rec=%b, required 0 0 0", expected_seq_num_o, fsm_state, recovering_o);
    end
    total++;
    if (resend_valid_o !== 1'b0 || resend_begin_o !== 8'd0 || resend_end_o !== 8'd0) begin
      bad++; $display("FAIL reset_resend: got v=%b b=%0d e=%0d, required 0 0 0", resend_valid_o, resend_begin_o, resend_end_o);
    end
    @(negedge clk);
    rst = 1'b1;
    send_msg(8'd3, 1'b0, 1'b0, 1'b0, 8'd0, V_IGN, 8'd0);
    idle(1);
  endtask

  task automatic test_in_order();
    do_connect();
    total++;
    if (expected_seq_num_o !== 8'd1 || fsm_state !== ST_ACTIVE) begin
      bad++; $display("FAIL connect: got exp=%0d state=%0d, required 1 1", expected_seq_num_o, fsm_state);
    end
    send_msg(8'd1, 1'b0, 1'b0, 1'b0, 8'd0, V_ACC, 8'd2);
    send_msg(8'd2, 1'b0, 1'b0, 1'b0, 8'd0, V_ACC, 8'd3);
    send_msg(8'd3, 1'b0, 1'b0, 1'b0, 8'd0, V_ACC, 8'd4);
    idle(1);
    total++;
    if (expected_seq_num_o !== 8'd4) begin
      bad++; $display("FAIL in_order_exp: got %0d, required 4", expected_seq_num_o);
    end
  endtask

  task automatic test_gap_recover();
    send_msg(8'd7, 1'b0, 1'b0, 1'b0, 8'd0, V_GAP, 8'd4);
    idle(1);
    total++;
    if (resend_valid_o !== 1'b1 || resend_begin_o !== 8'd4 || resend_end_o !== 8'd7 || recovering_o !== 1'b1) begin
      bad++; $display("FAIL gap_request: got v=%b b=%0d e=%0d rec=%b, required 1 4 7 1", resend_valid_o, resend_begin_o, resend_end_o, recovering_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (resend_valid_o !== 1'b1 || resend_begin_o !== 8'd4 || resend_end_o !== 8'd7) begin
        bad++; $display("FAIL resend_hold: cycle %0d got v=%b b=%0d e=%0d, required 1 4 7", i, resend_valid_o, resend_begin_o, resend_end_o);
      end
    end
    resend_ready_i = 1'b1;
    @(negedge clk);
    resend_ready_i = 1'b0;
    total++;
    if (resend_valid_o !== 1'b0) begin
      bad++; $display("FAIL resend_drop: got v=%b, required 0", resend_valid_o);
    end
    send_msg(8'd4, 1'b0, 1'b0, 1'b0, 8'd0, V_ACC, 8'd5);
    send_msg(8'd6, 1'b0, 1'b0, 1'b0, 8'd0, V_IGN, 8'd5);
    send_msg(8'd5, 1'b0, 1'b1, 1'b1, 8'd8, V_ACC, 8'd8);
    idle(1);
    total++;
    if (recovering_o !== 1'b0 || fsm_state !== ST_ACTIVE || expected_seq_num_o !== 8'd8) begin
      bad++; $display("FAIL recover_exit: got rec=%b state=%0d exp=%0d, required 0 1 8", recovering_o, fsm_state, expected_seq_num_o);
    end
  endtask

  task automatic test_possdup();
`ifdef FIX_SEQ_POSSDUP_EN
    send_msg(8'd5, 1'b1, 1'b0, 1'b0, 8'd0, V_IGN, 8'd8);
    send_msg(8'd5, 1'b0, 1'b0, 1'b0, 8'd0, V_FAT, 8'd8);
`else
    send_msg(8'd5, 1'b1, 1'b0, 1'b0, 8'd0, V_FAT, 8'd8);
    send_msg(8'd5, 1'b0, 1'b0, 1'b0, 8'd0, V_IGN, 8'd8);
`endif
    send_msg(8'd8, 1'b0, 1'b0, 1'b0, 8'd0, V_IGN, 8'd8);
    send_msg(8'd9, 1'b0, 1'b0, 1'b0, 8'd0, V_IGN, 8'd8);
    idle(1);
    total++;
    if (fsm_state !== ST_HALT) begin
      bad++; $display("FAIL halt_state: got %0d, required 3", fsm_state);
    end
  endtask

  task automatic test_wrap_seqreset();
    do_connect();
    send_msg(8'd1, 1'b0, 1'b1, 1'b0, 8'd255, V_ACC, 8'd255);
    send_msg(8'd255, 1'b0, 1'b0, 1'b0, 8'd0, V_ACC, 8'd1);
    send_msg(8'd0, 1'b0, 1'b1, 1'b0, 8'h40, V_ACC, 8'h40);
    send_msg(8'd0, 1'b0, 1'b1, 1'b0, 8'h40, V_ACC, 8'h40);
    send_msg(8'd0, 1'b0, 1'b1, 1'b0, 8'h10, V_FAT, 8'h40);
    idle(1);
    total++;
    if (fsm_state !== ST_HALT) begin
      bad++; $display("FAIL seqreset_halt: got %0d, required 3", fsm_state);
    end
  endtask

  task automatic test_fatal_cases();
    do_connect();
    send_msg(8'd0, 1'b0, 1'b0, 1'b0, 8'd0, V_FAT, 8'd1);
    do_connect();
    send_msg(8'd1, 1'b0, 1'b1, 1'b1, 8'd1, V_FAT, 8'd1);
    idle(1);
  endtask

  task automatic test_disconnect();
    do_connect();
    send_msg(8'd1, 1'b0, 1'b0, 1'b0, 8'd0, V_ACC, 8'd2);
    send_msg(8'd9, 1'b0, 1'b0, 1'b0, 8'd0, V_GAP, 8'd2);
    idle(1);
    total++;
    if (resend_valid_o !== 1'b1 || resend_begin_o !== 8'd2 || resend_end_o !== 8'd9 || fsm_state !== ST_RECOVER) begin
      bad++; $display("FAIL gap9: got v=%b b=%0d e=%0d st=%0d, required 1 2 9 2", resend_valid_o, resend_begin_o, resend_end_o, fsm_state);
    end
    send_msg(8'd0, 1'b0, 1'b1, 1'b0, 8'd10, V_ACC, 8'd10);
    send_msg(8'd12, 1'b0, 1'b0, 1'b0, 8'd0, V_GAP, 8'd10);
    idle(1);
    total++;
    if (resend_valid_o !== 1'b1 || resend_begin_o !== 8'd2 || resend_end_o !== 8'd12 || fsm_state !== ST_RECOVER) begin
      bad++; $display("FAIL gap_merge: got v=%b b=%0d e=%0d st=%0d, required 1 2 12 2", resend_valid_o, resend_begin_o, resend_end_o, fsm_state);
    end
    @(negedge clk);
    disconnect_i  = 1'b1;
    msg_valid_i   = 1'b1;
    msg_seq_num_i = 8'd10;
    @(negedge clk);
    clear_inputs();
    total++;
    if (resend_valid_o !== 1'b0 || fsm_state !== ST_IDLE || expected_seq_num_o !== 8'd10) begin
      bad++; $display("FAIL disconnect: got v=%b st=%0d exp=%0d, required 0 0 10", resend_valid_o, fsm_state, expected_seq_num_o);
    end
    send_msg(8'd10, 1'b0, 1'b0, 1'b0, 8'd0, V_IGN, 8'd10);
    @(negedge clk);
    clear_inputs();
    connect_i     = 1'b1;
    msg_valid_i   = 1'b1;
    msg_seq_num_i = 8'd5;
    @(negedge clk);
    clear_inputs();
    total++;
    if (expected_seq_num_o !== 8'd1 || fsm_state !== ST_ACTIVE) begin
      bad++; $display("FAIL connect_with_msg: got exp=%0d st=%0d, required 1 1", expected_seq_num_o, fsm_state);
    end
  endtask

  task automatic test_reset_mid();
    send_msg(8'd4, 1'b0, 1'b0, 1'b0, 8'd0, V_GAP, 8'd1);
    idle(1);
    total++;
    if (resend_valid_o !== 1'b1 || recovering_o !== 1'b1) begin
      bad++; $display("FAIL pre_reset: got v=%b rec=%b, required 1 1", resend_valid_o, recovering_o);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (resend_valid_o !== 1'b0 || resend_begin_o !== 8'd0 || resend_end_o !== 8'd0 || recovering_o !== 1'b0 ||
        expected_seq_num_o !== 8'd0 || fsm_state !== ST_IDLE || {accept_o, ignore_o, gap_o, fatal_o} !== 4'b0000) begin
      bad++; $display("FAIL async_reset: got v=%b b=%0d e=%0d rec=%b exp=%0d st=%0d, required all 0",
                      resend_valid_o, resend_begin_o, resend_end_o, recovering_o, expected_seq_num_o, fsm_state);
    end
    @(negedge clk);
    rst = 1'b1;
    send_msg(8'd1, 1'b0, 1'b0, 1'b0, 8'd0, V_IGN, 8'd0);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_gap_recover();
    test_possdup();
    test_wrap_seqreset();
    test_fatal_cases();
    test_disconnect();
    test_reset_mid();
    idle(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL verdict_missing: %0d expected verdicts never arrived, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
